// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (read-only) and data (load/store) requesters.
// Latency: request sampled at a grant edge, LATENCY busy cycles, done pulses in the following cycle.
// Backpressure: requesters are held via combinational stalls until their done pulse; no abort once granted.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_d;
  logic       busy, completing;
  logic       i_elig, d_elig;
  logic       grant_i, grant_d;

  // Stalls follow the raw request level and drop in the done cycle.
  assign i_stall = i_req & ~i_done;
  assign d_stall = (d_read | d_write) & ~d_done;

  // Arbitration and next state. A class is not eligible while its done pulse
  // is high, nor on its own completion edge: its held request at that point
  // is the one just served, so re-granting it would repeat the access.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    completing = busy && (cnt == 4'd0);
    i_elig     = i_req & ~i_done & ~(completing && state == BUSY_I);
    d_elig     = (d_read | d_write) & ~d_done & ~(completing && state == BUSY_D);
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    if (!busy || completing) begin
      // From IDLE data wins; at a completion edge the class not served last wins.
      grant_d = d_elig & (~i_elig | ~busy | ~last_d);
      grant_i = i_elig & ~grant_d;
      if (grant_d)      state_nxt = BUSY_D;
      else if (grant_i) state_nxt = BUSY_I;
      else              state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory port controls, latency counter, read-data capture and done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      last_d    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      i_done <= completing && (state == BUSY_I);
      d_done <= completing && (state == BUSY_D);
      if (completing && state == BUSY_I)           i_rdata <= mem_rdata;
      if (completing && state == BUSY_D && mem_re) d_rdata <= mem_rdata;

      if (grant_d) begin
        // Write takes precedence when both load and store are asserted.
        cnt       <= CNT_INIT;
        last_d    <= 1'b1;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_we    <= d_write;
        mem_re    <= ~d_write & d_read;
      end else if (grant_i) begin
        cnt      <= CNT_INIT;
        last_d   <= 1'b0;
        mem_addr <= i_addr;
        mem_re   <= 1'b1;
        mem_we   <= 1'b0;
      end else if (completing) begin
        mem_re <= 1'b0;
        mem_we <= 1'b0;
      end else if (busy) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with LATENCY=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each step compares against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        i_stall;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_rdata;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .LATENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_stall   (i_stall),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_stall   (d_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    i_req     = 1'b1;
    i_addr    = 16'h0055;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = 16'h0000;
    d_wdata   = 16'h0000;
    mem_rdata = 16'h0000;

    // Reset held two cycles with a fetch request pending.
    tick();
    tick();
    chk("rst_mem_re",   32'(mem_re),   32'h0);
    chk("rst_mem_we",   32'(mem_we),   32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_i_done",   32'(i_done),   32'h0);
    chk("rst_d_done",   32'(d_done),   32'h0);
    chk("rst_i_rdata",  32'(i_rdata),  32'h0);
    chk("rst_d_rdata",  32'(d_rdata),  32'h0);
    chk("rst_i_stall",  32'(i_stall),  32'h1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_mem_re",   32'(mem_re),   32'h1);
    chk("post_rst_mem_addr", 32'(mem_addr), 32'h0055);
    mem_rdata = 16'h1111;
    tick();
    tick();
    chk("post_rst_i_done",  32'(i_done),  32'h1);
    chk("post_rst_i_rdata", 32'(i_rdata), 32'h1111);
    i_req = 1'b0;
    tick();

    // Single fetch.
    i_req     = 1'b1;
    i_addr    = 16'h0040;
    mem_rdata = 16'hBEEF;
    tick();
    chk("f_c1_mem_re",   32'(mem_re),   32'h1);
    chk("f_c1_mem_addr", 32'(mem_addr), 32'h0040);
    chk("f_c1_i_stall",  32'(i_stall),  32'h1);
    chk("f_c1_i_done",   32'(i_done),   32'h0);
    tick();
    chk("f_c2_mem_re",   32'(mem_re),   32'h1);
    chk("f_c2_i_stall",  32'(i_stall),  32'h1);
    tick();
    chk("f_done",        32'(i_done),   32'h1);
    chk("f_i_rdata",     32'(i_rdata),  32'hBEEF);
    chk("f_done_stall",  32'(i_stall),  32'h0);
    chk("f_done_mem_re", 32'(mem_re),   32'h0);
    i_req = 1'b0;
    tick();
    chk("f_after_i_done", 32'(i_done),  32'h0);
    chk("f_no_reissue",   32'(mem_re),  32'h0);
    chk("f_rdata_hold",   32'(i_rdata), 32'hBEEF);

    // Simultaneous fetch and load: data first, fetch back-to-back.
    i_req     = 1'b1;
    i_addr    = 16'h0010;
    d_read    = 1'b1;
    d_addr    = 16'h2000;
    mem_rdata = 16'hCAFE;
    tick();
    chk("s_c1_mem_addr", 32'(mem_addr), 32'h2000);
    chk("s_c1_mem_re",   32'(mem_re),   32'h1);
    chk("s_c1_d_stall",  32'(d_stall),  32'h1);
    chk("s_c1_i_stall",  32'(i_stall),  32'h1);
    tick();
    tick();
    chk("s_d_done",      32'(d_done),   32'h1);
    chk("s_d_rdata",     32'(d_rdata),  32'hCAFE);
    chk("s_i_not_done",  32'(i_done),   32'h0);
    chk("s_c3_mem_addr", 32'(mem_addr), 32'h0010);
    chk("s_c3_mem_re",   32'(mem_re),   32'h1);
    d_read    = 1'b0;
    mem_rdata = 16'h7777;
    tick();
    chk("s_c4_d_done",   32'(d_done),   32'h0);
    chk("s_c4_mem_re",   32'(mem_re),   32'h1);
    tick();
    chk("s_i_done",      32'(i_done),   32'h1);
    chk("s_i_rdata",     32'(i_rdata),  32'h7777);
    chk("s_c5_mem_re",   32'(mem_re),   32'h0);
    i_req = 1'b0;
    tick();

    // Store: d_rdata must keep the previous load value.
    d_write   = 1'b1;
    d_addr    = 16'h0100;
    d_wdata   = 16'h1234;
    mem_rdata = 16'hDEAD;
    tick();
    chk("w_c1_mem_we",    32'(mem_we),    32'h1);
    chk("w_c1_mem_re",    32'(mem_re),    32'h0);
    chk("w_c1_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("w_c1_mem_addr",  32'(mem_addr),  32'h0100);
    tick();
    chk("w_c2_mem_we",    32'(mem_we),    32'h1);
    tick();
    chk("w_d_done",       32'(d_done),    32'h1);
    chk("w_d_rdata_keep", 32'(d_rdata),   32'hCAFE);
    chk("w_done_mem_we",  32'(mem_we),    32'h0);
    d_write = 1'b0;
    tick();

    // Continuous contention with fresh addresses: grants alternate D,I,D,I,D.
    d_read = 1'b1;
    d_addr = 16'h3000;
    i_req  = 1'b1;
    i_addr = 16'h0020;
    tick();
    chk("c_g0_mem_addr", 32'(mem_addr), 32'h3000);
    chk("c_g0_mem_re",   32'(mem_re),   32'h1);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] exp_addr;
      int          j;
      tick();
      tick();
      j = k + 1;
      exp_addr = (j % 2 == 0) ? 16'(16'h3000 + j / 2) : 16'(16'h0020 + j / 2);
      if (k % 2 == 0) begin
        chk($sformatf("c_k%0d_d_done", k), 32'(d_done), 32'h1);
        chk($sformatf("c_k%0d_i_done", k), 32'(i_done), 32'h0);
        d_addr = d_addr + 16'h1;
      end else begin
        chk($sformatf("c_k%0d_i_done", k), 32'(i_done), 32'h1);
        chk($sformatf("c_k%0d_d_done", k), 32'(d_done), 32'h0);
        i_addr = i_addr + 16'h1;
      end
      chk($sformatf("c_g%0d_mem_addr", j), 32'(mem_addr), 32'(exp_addr));
    end
    // Both requests drop while the fifth grant (load at 0x3002) is in flight.
    i_req     = 1'b0;
    d_read    = 1'b0;
    mem_rdata = 16'h5A5A;
    tick();
    chk("c_drop_mem_re", 32'(mem_re), 32'h1);
    tick();
    chk("c_drop_d_done", 32'(d_done),  32'h1);
    chk("c_drop_rdata",  32'(d_rdata), 32'h5A5A);
    tick();
    chk("c_idle_mem_re", 32'(mem_re), 32'h0);
    chk("c_idle_d_done", 32'(d_done), 32'h0);

    // Load and store both asserted: write takes precedence.
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 16'h0200;
    d_wdata = 16'hABCD;
    tick();
    chk("rw_mem_we", 32'(mem_we), 32'h1);
    chk("rw_mem_re", 32'(mem_re), 32'h0);
    tick();
    tick();
    chk("rw_d_done", 32'(d_done),  32'h1);
    chk("rw_rdata",  32'(d_rdata), 32'h5A5A);
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();

    // Reset during the first busy cycle of a load aborts it silently.
    d_read = 1'b1;
    d_addr = 16'h4000;
    tick();
    chk("ra_c1_mem_re", 32'(mem_re), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("ra_mem_re",   32'(mem_re),   32'h0);
    chk("ra_mem_addr", 32'(mem_addr), 32'h0);
    chk("ra_d_done",   32'(d_done),   32'h0);
    chk("ra_d_rdata",  32'(d_rdata),  32'h0);
    d_read = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("ra2_d_done", 32'(d_done), 32'h0);
    chk("ra2_mem_re", 32'(mem_re), 32'h0);
    tick();
    chk("ra3_d_done", 32'(d_done), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
